// File: rtl/lp_ctrl_lane_gen.sv
// D-PHY lane LP/HS/ULPS sequencer with a built-in per-state timer.
// LANE_MODE selects data-lane (escape ULPS entry, TxReadyHS) or clock-lane behaviour.
module lp_ctrl_lane_gen #(
  parameter int TIMER_WIDTH  = 16,
  parameter int LANE_MODE    = 0,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 1,
  parameter int T_HS_ZERO    = 4,
  parameter int T_HS_TRAIL   = 4,
  parameter int T_WAKEUP     = 20000
) (
  input  logic       TxClkEsc,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic       ForceTxStopmode,
  input  logic       TxRequestHS,
  input  logic       TxUlps,
  input  logic       TxUlpsExit,
  output logic       Stopstate,
  output logic       UlpsActiveNot,
  output logic [1:0] LP_MODE_SEQ,
  output logic       HS_EN,
  output logic       HS_ZERO_EN,
  output logic       TxReadyHS,
  output logic       ULP_CG_EN,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_OFF       = 4'd0,
    S_STOP      = 4'd1,
    S_HS_RQST   = 4'd2,
    S_HS_PREP   = 4'd3,
    S_HS_ZERO   = 4'd4,
    S_HS_TX     = 4'd5,
    S_HS_TRAIL  = 4'd6,
    S_ULPS_RQST = 4'd7,
    S_ULPS      = 4'd8,
    S_ULPS_EXIT = 4'd9
  } state_t;

  localparam bit CLK_LANE = (LANE_MODE == 1);
  localparam logic [TIMER_WIDTH-1:0] LD_LPX   = TIMER_WIDTH'(T_LPX - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_PREP  = TIMER_WIDTH'(T_HS_PREPARE - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_ZERO  = TIMER_WIDTH'(T_HS_ZERO - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_TRAIL = TIMER_WIDTH'(T_HS_TRAIL - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_WAKE  = TIMER_WIDTH'(T_WAKEUP - 1);

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] tmr, tmr_nxt;
  logic [1:0]             ph, ph_nxt;   // escape-entry phase (data lane ULPS_RQST)
  logic                   done;

  assign done = (tmr == '0);

  // state, timer and phase registers
  always_ff @(posedge TxClkEsc or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      tmr   <= '0;
      ph    <= 2'd0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      ph    <= ph_nxt;
    end
  end

  // next state; the timer is reloaded with T-1 on every entry to a timed state
  always_comb begin
    state_nxt = state;
    tmr_nxt   = done ? tmr : tmr - TIMER_WIDTH'(1);
    ph_nxt    = ph;
    if (!Enable) begin
      state_nxt = S_OFF;
      tmr_nxt   = '0;
      ph_nxt    = 2'd0;
    end else if (ForceTxStopmode && state != S_OFF) begin
      state_nxt = S_STOP;
      tmr_nxt   = '0;
      ph_nxt    = 2'd0;
    end else begin
      case (state)
        S_OFF:  state_nxt = S_STOP;
        S_STOP: begin
          if (TxRequestHS) begin
            state_nxt = S_HS_RQST;
            tmr_nxt   = LD_LPX;
          end else if (TxUlps) begin
            state_nxt = S_ULPS_RQST;
            tmr_nxt   = LD_LPX;
            ph_nxt    = 2'd0;
          end
        end
        S_HS_RQST: if (done) begin state_nxt = S_HS_PREP; tmr_nxt = LD_PREP; end
        S_HS_PREP: if (done) begin state_nxt = S_HS_ZERO; tmr_nxt = LD_ZERO; end
        S_HS_ZERO: if (done) state_nxt = S_HS_TX;
        S_HS_TX:   if (!TxRequestHS) begin state_nxt = S_HS_TRAIL; tmr_nxt = LD_TRAIL; end
        S_HS_TRAIL: if (done) state_nxt = S_STOP;
        S_ULPS_RQST: begin
          if (done) begin
            if (CLK_LANE || ph == 2'd3) begin
              state_nxt = S_ULPS;
              ph_nxt    = 2'd0;
            end else begin
              ph_nxt  = ph + 2'd1;
              tmr_nxt = LD_LPX;
            end
          end
        end
        S_ULPS:      if (TxUlpsExit) begin state_nxt = S_ULPS_EXIT; tmr_nxt = LD_WAKE; end
        S_ULPS_EXIT: if (done && !TxUlpsExit) state_nxt = S_STOP;
        default: begin
          state_nxt = S_OFF;
          tmr_nxt   = '0;
          ph_nxt    = 2'd0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    Stopstate     = 1'b0;
    UlpsActiveNot = 1'b1;
    LP_MODE_SEQ   = 2'b00;
    HS_EN         = 1'b0;
    HS_ZERO_EN    = 1'b0;
    TxReadyHS     = 1'b0;
    ULP_CG_EN     = 1'b0;
    case (state)
      S_STOP:    begin Stopstate = 1'b1; LP_MODE_SEQ = 2'b11; end
      S_HS_RQST: LP_MODE_SEQ = 2'b01;
      S_HS_ZERO, S_HS_TRAIL: begin HS_EN = 1'b1; HS_ZERO_EN = 1'b1; end
      S_HS_TX:   begin HS_EN = 1'b1; TxReadyHS = !CLK_LANE; end
      S_ULPS_RQST: begin
        if (CLK_LANE) LP_MODE_SEQ = 2'b10;
        else case (ph)
          2'd0:    LP_MODE_SEQ = 2'b10;
          2'd2:    LP_MODE_SEQ = 2'b01;
          default: LP_MODE_SEQ = 2'b00;
        endcase
      end
      S_ULPS:      begin UlpsActiveNot = 1'b0; ULP_CG_EN = 1'b1; end
      S_ULPS_EXIT: LP_MODE_SEQ = 2'b10;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lp_ctrl_lane_gen.sv
// Bench: a data lane (default timing) and a clock lane (short timing) share the
// same stimulus; each is checked every cycle against an elapsed-time model.
module tb_lp_ctrl_lane_gen;

  logic TxClkEsc = 1'b0;
  logic rst_n = 1'b0, Enable = 1'b0, ForceTxStopmode = 1'b0;
  logic TxRequestHS = 1'b0, TxUlps = 1'b0, TxUlpsExit = 1'b0;

  logic       stop0, uan0, hsen0, hsz0, rdy0, cg0, stop1, uan1, hsen1, hsz1, rdy1, cg1;
  logic [1:0] lp0, lp1;
  logic [3:0] st0, st1;

  always #5 TxClkEsc = ~TxClkEsc;

  lp_ctrl_lane_gen #(.LANE_MODE(0)) dut0 (
    .TxClkEsc(TxClkEsc), .rst_n(rst_n), .Enable(Enable), .ForceTxStopmode(ForceTxStopmode),
    .TxRequestHS(TxRequestHS), .TxUlps(TxUlps), .TxUlpsExit(TxUlpsExit),
    .Stopstate(stop0), .UlpsActiveNot(uan0), .LP_MODE_SEQ(lp0), .HS_EN(hsen0),
    .HS_ZERO_EN(hsz0), .TxReadyHS(rdy0), .ULP_CG_EN(cg0), .state_dbg(st0));

  lp_ctrl_lane_gen #(.LANE_MODE(1), .T_LPX(3), .T_HS_PREPARE(2), .T_HS_ZERO(2),
                     .T_HS_TRAIL(3), .T_WAKEUP(5)) dut1 (
    .TxClkEsc(TxClkEsc), .rst_n(rst_n), .Enable(Enable), .ForceTxStopmode(ForceTxStopmode),
    .TxRequestHS(TxRequestHS), .TxUlps(TxUlps), .TxUlpsExit(TxUlpsExit),
    .Stopstate(stop1), .UlpsActiveNot(uan1), .LP_MODE_SEQ(lp1), .HS_EN(hsen1),
    .HS_ZERO_EN(hsz1), .TxReadyHS(rdy1), .ULP_CG_EN(cg1), .state_dbg(st1));

  logic [11:0] o0, o1;
  assign o0 = {st0, lp0, stop0, uan0, hsen0, hsz0, rdy0, cg0};
  assign o1 = {st1, lp1, stop1, uan1, hsen1, hsz1, rdy1, cg1};
  localparam logic [11:0] RST_PACK = 12'b0000_00_0_1_0_0_0_0;

  int n_vec = 0, n_bad = 0;

  // model: state name (state_dbg numbering) and cycles spent in it so far
  int m_st[2], m_age[2];

  function automatic int p_lpx(int l);   return l ? 3 : 2;     endfunction
  function automatic int p_prep(int l);  return l ? 2 : 1;     endfunction
  function automatic int p_zero(int l);  return l ? 2 : 4;     endfunction
  function automatic int p_trail(int l); return l ? 3 : 4;     endfunction
  function automatic int p_wake(int l);  return l ? 5 : 20000; endfunction

  task automatic m_reset();
    for (int l = 0; l < 2; l++) begin m_st[l] = 0; m_age[l] = 0; end
  endtask

  task automatic m_step();
    for (int l = 0; l < 2; l++) begin
      int st, nx, el;
      st = m_st[l]; nx = st; el = m_age[l] + 1;
      if (!Enable) nx = 0;
      else if (ForceTxStopmode && st != 0) nx = 1;
      else case (st)
        0: nx = 1;
        1: nx = TxRequestHS ? 2 : (TxUlps ? 7 : 1);
        2: if (el >= p_lpx(l))   nx = 3;
        3: if (el >= p_prep(l))  nx = 4;
        4: if (el >= p_zero(l))  nx = 5;
        5: if (!TxRequestHS)     nx = 6;
        6: if (el >= p_trail(l)) nx = 1;
        7: if (el >= (l ? 1 : 4) * p_lpx(l)) nx = 8;
        8: if (TxUlpsExit)       nx = 9;
        9: if (el >= p_wake(l) && !TxUlpsExit) nx = 1;
        default: nx = 0;
      endcase
      m_age[l] = (nx != st) ? 0 : el;
      m_st[l]  = nx;
    end
  endtask

  function automatic logic [11:0] m_out(int l);
    int st; logic [1:0] lp;
    st = m_st[l];
    case (st)
      1: lp = 2'b11;
      2: lp = 2'b01;
      7: begin
        if (l == 1) lp = 2'b10;
        else case (m_age[l] / p_lpx(l))
          0: lp = 2'b10;
          2: lp = 2'b01;
          default: lp = 2'b00;
        endcase
      end
      9: lp = 2'b10;
      default: lp = 2'b00;
    endcase
    return {4'(st), lp, st == 1, st != 8, st >= 4 && st <= 6, st == 4 || st == 6,
            st == 5 && l == 0, st == 8};
  endfunction

  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance one cycle; model follows the edge, outputs are checked on the falling edge
  task automatic tick();
    @(posedge TxClkEsc);
    m_step();
    @(negedge TxClkEsc);
    cmp("data_lane", o0, m_out(0));
    cmp("clk_lane",  o1, m_out(1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] exp_hs [8];
  logic [1:0] exp_ul [8];
  int cnt;

  initial begin
    exp_hs = '{4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
    exp_ul = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    m_reset();
    #12;
    cmp("reset0", o0, RST_PACK);
    cmp("reset1", o1, RST_PACK);
    @(negedge TxClkEsc); rst_n = 1'b1;
    tick();
    cmp("off_hold", {8'd0, st0}, 12'd0);
    Enable = 1'b1;
    tick();
    cmp("stop_entry", {st0, lp0, stop0}, {4'd1, 2'b11, 1'b1});

    // HS burst on the data lane
    TxRequestHS = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp("hs_seq", {8'd0, st0}, {8'd0, exp_hs[i]});
    end
    cmp("hs_ready", {11'd0, rdy0}, 12'd1);
    ticks(5);
    cmp("clk_hs_tx", {7'd0, st1, rdy1}, {7'd0, 4'd5, 1'b0});
    TxRequestHS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("hs_trail", {8'd0, st0}, 12'd6);
    end
    tick();
    cmp("trail_stop", {8'd0, st0}, 12'd1);

    // ULPS entry: data lane escape sequence, clock lane LP-10 for T_LPX
    TxUlps = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp("ulps_lp", {10'd0, lp0}, {10'd0, exp_ul[i]});
      if (i == 0) cmp("clk_ulps_lp", {10'd0, lp1}, {10'd0, 2'b10});
      if (i == 3) cmp("clk_ulps_in", {8'd0, st1}, 12'd8);
    end
    TxUlps = 1'b0;
    tick();
    cmp("ulps_in", {st0, lp0, uan0, cg0}, {4'd8, 2'b00, 1'b0, 1'b1});

    // wake-up: exit held 20005 cycles
    TxUlpsExit = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20005; i++) begin
      tick();
      if (lp0 == 2'b10 && st0 == 4'd9) cnt++;
    end
    TxUlpsExit = 1'b0;
    tick();
    cmp("wake_len", 12'(cnt), 12'd20005);
    cmp("wake_stop", {8'd0, st0}, 12'd1);

    // both requests in STOP: HS wins; drop in HS_PREP gives one HS_TX cycle
    TxRequestHS = 1'b1; TxUlps = 1'b1;
    tick();
    cmp("prio_hs", {4'd0, st0, st1}, {4'd0, 4'd2, 4'd2});
    ticks(2);
    cmp("in_prep", {8'd0, st0}, 12'd3);
    TxRequestHS = 1'b0; TxUlps = 1'b0;
    ticks(5);
    cmp("one_tx", {7'd0, st0, rdy0}, {7'd0, 4'd5, 1'b1});
    tick();
    cmp("then_trail", {8'd0, st0}, 12'd6);
    ticks(12);

    // ForceTxStopmode in HS_ZERO
    TxRequestHS = 1'b1;
    ticks(4);
    cmp("in_zero", {8'd0, st0}, 12'd4);
    ForceTxStopmode = 1'b1; TxRequestHS = 1'b0;
    tick();
    cmp("force_zero", {7'd0, st0, hsen0}, {7'd0, 4'd1, 1'b0});
    ForceTxStopmode = 1'b0;

    // ForceTxStopmode in ULPS_EXIT
    TxUlps = 1'b1;
    ticks(9);
    TxUlps = 1'b0; TxUlpsExit = 1'b1;
    ticks(3);
    cmp("in_exit", {8'd0, st0}, 12'd9);
    ForceTxStopmode = 1'b1;
    tick();
    cmp("force_exit", {7'd0, st0, hsen0}, {7'd0, 4'd1, 1'b0});
    ForceTxStopmode = 1'b0; TxUlpsExit = 1'b0;

    // Enable drop in HS_TX
    TxRequestHS = 1'b1;
    ticks(8);
    cmp("in_tx", {8'd0, st0}, 12'd5);
    Enable = 1'b0;
    tick();
    cmp("en_off", o0, RST_PACK);
    Enable = 1'b1; TxRequestHS = 1'b0;

    // randomized run with one asynchronous reset in the middle
    for (int c = 0; c < 40000; c++) begin
      Enable          = ($urandom_range(399) != 0);
      ForceTxStopmode = ($urandom_range(249) == 0);
      if ($urandom_range(14) == 0) TxRequestHS = ~TxRequestHS;
      if ($urandom_range(24) == 0) TxUlps      = ~TxUlps;
      if ($urandom_range(29) == 0) TxUlpsExit  = ~TxUlpsExit;
      if (c == 20000) begin
        rst_n = 1'b0;
        #2;
        cmp("async_rst0", o0, RST_PACK);
        cmp("async_rst1", o1, RST_PACK);
        m_reset();
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lp_ctrl_lane_gen.md
Name: lp_ctrl_lane_gen

Overview:
Parametrised successor to the clock-lane LP controller. It sequences one D-PHY lane through LP, HS-entry, HS, HS-exit and ULPS states. LANE_MODE selects clock-lane or data-lane behaviour. The timer is built in and loaded from per-state timing parameters, so no external time_wait/time_flag pair is needed. Sits between the PPI interface and the LP/HS driver muxes, one instance per lane.

Parameters:
TIMER_WIDTH, 16, width of the internal down-counter; every T_* value must fit in it.
LANE_MODE, 0, 0 = data lane, 1 = clock lane.
T_LPX, 2, TxClkEsc cycles per LPX phase (≥1).
T_HS_PREPARE, 1, cycles of LP-00 before HS drive (≥1).
T_HS_ZERO, 4, cycles of HS-0 before payload or clock (≥1).
T_HS_TRAIL, 4, cycles of HS trail; for the clock lane this includes T_POST (≥1).
T_WAKEUP, 20000, cycles of Mark-1 (LP-10) on ULPS exit (≥1).

Ports:
TxClkEsc  in  1  escape clock; sole clock.
rst_n  in  1  asynchronous active-low reset.
Enable  in  1  lane enable; low forces OFF.
ForceTxStopmode  in  1  abort to STOP.
TxRequestHS  in  1  HS request (clock-lane request for LANE_MODE=1).
TxUlps  in  1  ULPS request (TxUlpsClk or TxUlpsEsc).
TxUlpsExit  in  1  ULPS exit request.
Stopstate  out  1  lane is in STOP.
UlpsActiveNot  out  1  low while in ULPS.
LP_MODE_SEQ  out  2  LP line state {Dp,Dn}.
HS_EN  out  1  HS driver enable.
HS_ZERO_EN  out  1  force HS-0 on the HS serializer.
TxReadyHS  out  1  data lane accepts HS byte; always 0 when LANE_MODE=1.
ULP_CG_EN  out  1  clock-gate enable in ULPS.
state_dbg  out  4  current state encoding.

Behaviour:
- Moore outputs are decoded from the registered state only. On reset the state is OFF and outputs are: Stopstate=0, UlpsActiveNot=1, LP_MODE_SEQ=00, HS_EN=0, HS_ZERO_EN=0, TxReadyHS=0, ULP_CG_EN=0, state_dbg=0.
- Timer: on entry to a timed state, load T−1; decrement each cycle; done when count==0. A timed state therefore lasts exactly T cycles.
- Global priority, evaluated every cycle: Enable=0 → OFF next cycle from any state. Otherwise, ForceTxStopmode=1 in any state other than OFF → STOP next cycle and the timer is cleared.
- States (state_dbg value: outputs; transition):
  - OFF(0): all reset values; Enable=1 → STOP.
  - STOP(1): LP=11, Stopstate=1. TxRequestHS → HS_RQST; else TxUlps → ULPS_RQST. TxRequestHS wins if both are high.
  - HS_RQST(2): LP=01 for T_LPX → HS_PREP.
  - HS_PREP(3): LP=00 for T_HS_PREPARE → HS_ZERO.
  - HS_ZERO(4): HS_EN=1, HS_ZERO_EN=1 for T_HS_ZERO → HS_TX.
  - HS_TX(5): HS_EN=1; TxReadyHS=1 if data lane; TxRequestHS=0 → HS_TRAIL.
  - HS_TRAIL(6): HS_EN=1, HS_ZERO_EN=1 for T_HS_TRAIL → STOP.
  - ULPS_RQST(7): clock lane drives LP=10 for T_LPX → ULPS. Data lane runs the escape entry LP-10, 00, 01, 00 with T_LPX each, using a 2-bit phase counter, → ULPS. Total 4·T_LPX cycles.
  - ULPS(8): LP=00, UlpsActiveNot=0, ULP_CG_EN=1; TxUlpsExit=1 → ULPS_EXIT.
  - ULPS_EXIT(9): LP=10, UlpsActiveNot=1. After T_WAKEUP cycles, stays until TxUlpsExit=0, then → STOP.
  - Unused encodings → OFF.
- TxRequestHS dropping during HS_RQST/HS_PREP/HS_ZERO does not abort entry. The sequence completes, spends 1 cycle in HS_TX (TxReadyHS=1 for 1 cycle on a data lane), then goes to HS_TRAIL.
- TxUlps dropping during ULPS_RQST does not abort; the lane still enters ULPS.
- In ULPS the timer is idle. TxUlps is ignored in ULPS.
- Reset asserted mid-sequence → OFF immediately (asynchronous). Outputs go to reset values and the phase counter and timer clear.

Test Plan:
- Reset, then Enable=1, LANE_MODE=0 → OFF for 0 cycles post-reset; 1 cycle later STOP, Stopstate=1, LP=11.
- STOP, pulse TxRequestHS high for 20 cycles (defaults) → LP=01 for 2 cycles, LP=00 for 1, HS_ZERO for 4, then TxReadyHS=1. Drop TxRequestHS → HS_TRAIL 4 cycles → STOP.
- Data lane, TxUlps=1 → LP sequence 10,10,00,00,01,01,00,00 (8 cycles) → ULPS with UlpsActiveNot=0 and ULP_CG_EN=1. TxUlpsExit=1 held 20005 cycles → LP=10 for 20005 cycles total, STOP on the cycle after release.
- LANE_MODE=1, TxUlps=1 → LP=10 for 2 cycles then ULPS. In HS_TX, TxReadyHS stays 0.
- ForceTxStopmode pulsed in HS_ZERO and in ULPS_EXIT → STOP on the next cycle, HS_EN=0. Enable dropped in HS_TX → OFF next cycle.
- TxRequestHS and TxUlps both high in STOP → HS_RQST. TxRequestHS dropped in HS_PREP → exactly 1 cycle of HS_TX.
